// File: rtl/machine_trap_ctrl.sv
// -----------------------------------------------------------------------------
// machine_trap_ctrl
//
// Machine-mode trap sequencer. Takes synchronous exceptions, machine-level
// interrupts and MRET from the commit stage, updates the trap CSRs
// (mepc/mcause/mtval), mstatus.MIE/MPIE/MPP and the current privilege level,
// flushes the pipeline and then hands the redirect PC to fetch over a
// valid/ready handshake.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   ex_valid/ex_code/ex_epc/ex_tval   exception from the oldest instruction
//   mret_valid                MRET committing
//   pc_next                   next PC, saved as mepc for interrupts
//   ext_irq                   asynchronous external interrupt (synchronized)
//   timer_irq, soft_irq       synchronous level interrupts
//   csr_mtvec, csr_mie        trap vector and interrupt enables from CSR file
//   mstatus_wen/mstatus_wdata CSR write of mstatus (mie/mpie/mpp only)
//   pipe_drained              pipeline empty after flush
//   redirect_ready            fetch accepts the redirect
//   ex_accept                 one-cycle pulse when an event is taken
//   flush                     pipeline flush request
//   redirect_valid/redirect_pc redirect to fetch
//   mepc, mcause, mtval, mip  trap CSR views
//   mstatus_mie/mpie/mpp, priv machine status and current privilege
// -----------------------------------------------------------------------------
module machine_trap_ctrl #(
  parameter bit HAS_U_MODE = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  logic [30:0] ex_code,
  input  logic [31:0] ex_epc,
  input  logic [31:0] ex_tval,
  input  logic        mret_valid,
  input  logic [31:0] pc_next,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        soft_irq,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mie,
  input  logic        mstatus_wen,
  input  logic [31:0] mstatus_wdata,
  input  logic        pipe_drained,
  input  logic        redirect_ready,
  output logic        ex_accept,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic [31:0] mip,
  output logic        mstatus_mie,
  output logic        mstatus_mpie,
  output logic [1:0]  mstatus_mpp,
  output logic [1:0]  priv
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DRAIN    = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  localparam logic [1:0] U_MODE    = 2'b00;
  localparam logic [1:0] RSVD_MODE = 2'b10;
  localparam logic [1:0] M_MODE    = 2'b11;

  localparam logic [1:0] TVEC_VECTORED = 2'b01;

  localparam logic [4:0] CODE_MSI = 5'd3;
  localparam logic [4:0] CODE_MTI = 5'd7;
  localparam logic [4:0] CODE_MEI = 5'd11;

  // Trap entry address; reserved mtvec modes fall back to direct mode.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                              input logic        is_irq,
                                              input logic [4:0]  code);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    case (tvec[1:0])
      TVEC_VECTORED: begin
        if (is_irq) begin
          trap_target = base + {25'd0, code, 2'b00};
        end else begin
          trap_target = base;
        end
      end
      default: trap_target = base;
    endcase
  endfunction

  // Legalize a software-written MPP: reserved encodings (and U when the
  // core has no user mode) read back as M so MRET can never enter them.
  function automatic logic [1:0] legal_mpp(input logic [1:0] v);
    case (v)
      RSVD_MODE: legal_mpp = M_MODE;
      U_MODE:    legal_mpp = HAS_U_MODE ? U_MODE : M_MODE;
      default:   legal_mpp = v;
    endcase
  endfunction

  // State and output flops
  state_t      state_q, state_d;
  logic [1:0]  ext_sync_q, ext_sync_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [1:0]  mstatus_mpp_q, mstatus_mpp_d;
  logic [1:0]  priv_q, priv_d;

  // Combinational event selection
  logic [31:0] mip_s;
  logic [31:0] irq_pend_s;
  logic        irq_take_s;
  logic [4:0]  irq_code_s;
  logic        ev_trap_s;
  logic        ev_mret_s;
  logic        ev_wen_s;
  logic [31:0] trap_cause_s;
  logic [31:0] trap_epc_s;
  logic [31:0] trap_tval_s;
  logic [31:0] trap_target_s;

  // Only mie (3), mpie (7) and mpp (12:11) of the written mstatus are kept.
  logic unused_wdata_s;
  assign unused_wdata_s = ^{mstatus_wdata[31:13], mstatus_wdata[10:8],
                            mstatus_wdata[6:4], mstatus_wdata[2:0]};

  // Pending-interrupt view and interrupt arbitration (MEI > MSI > MTI).
  always_comb begin
    mip_s      = 32'h0000_0000;
    mip_s[11]  = ext_sync_q[1];
    mip_s[7]   = timer_irq;
    mip_s[3]   = soft_irq;
    irq_pend_s = mip_s & csr_mie;
    // Lower privilege always takes M interrupts; in M they need mstatus.MIE.
    irq_take_s = (irq_pend_s != 32'h0000_0000) &&
                 ((priv_q != M_MODE) || mstatus_mie_q);
    if (irq_pend_s[11]) begin
      irq_code_s = CODE_MEI;
    end else if (irq_pend_s[3]) begin
      irq_code_s = CODE_MSI;
    end else if (irq_pend_s[7]) begin
      irq_code_s = CODE_MTI;
    end else begin
      irq_code_s = 5'd0;
    end
  end

  // Event priority in IDLE: exception, enabled interrupt, MRET, CSR write.
  always_comb begin
    ev_trap_s     = 1'b0;
    ev_mret_s     = 1'b0;
    ev_wen_s      = 1'b0;
    trap_cause_s  = 32'h0000_0000;
    trap_epc_s    = 32'h0000_0000;
    trap_tval_s   = 32'h0000_0000;
    trap_target_s = 32'h0000_0000;
    if (state_q == IDLE) begin
      if (ex_valid) begin
        ev_trap_s     = 1'b1;
        trap_cause_s  = {1'b0, ex_code};
        trap_epc_s    = {ex_epc[31:2], 2'b00};
        trap_tval_s   = ex_tval;
        trap_target_s = trap_target(csr_mtvec, 1'b0, 5'd0);
      end else if (irq_take_s) begin
        ev_trap_s     = 1'b1;
        trap_cause_s  = {1'b1, 26'd0, irq_code_s};
        trap_epc_s    = {pc_next[31:2], 2'b00};
        trap_tval_s   = 32'h0000_0000;
        trap_target_s = trap_target(csr_mtvec, 1'b1, irq_code_s);
      end else if (mret_valid) begin
        ev_mret_s = 1'b1;
      end else if (mstatus_wen) begin
        ev_wen_s = 1'b1;
      end else begin
        ev_wen_s = 1'b0;
      end
    end else begin
      // Events are held off while a redirect is in flight.
      ev_trap_s = 1'b0;
    end
  end

  // Next-state logic for the sequencer and all architectural state.
  always_comb begin
    state_d          = state_q;
    ext_sync_d       = {ext_sync_q[0], ext_irq};
    flush_d          = flush_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    mstatus_mie_d    = mstatus_mie_q;
    mstatus_mpie_d   = mstatus_mpie_q;
    mstatus_mpp_d    = mstatus_mpp_q;
    priv_d           = priv_q;

    case (state_q)
      IDLE: begin
        if (ev_trap_s) begin
          state_d        = DRAIN;
          flush_d        = 1'b1;
          redirect_pc_d  = trap_target_s;
          mcause_d       = trap_cause_s;
          mepc_d         = trap_epc_s;
          mtval_d        = trap_tval_s;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          mstatus_mpp_d  = priv_q;
          priv_d         = M_MODE;
        end else if (ev_mret_s) begin
          state_d        = DRAIN;
          flush_d        = 1'b1;
          redirect_pc_d  = mepc_q;
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
          priv_d         = mstatus_mpp_q;
          mstatus_mpp_d  = HAS_U_MODE ? U_MODE : M_MODE;
        end else if (ev_wen_s) begin
          mstatus_mie_d  = mstatus_wdata[3];
          mstatus_mpie_d = mstatus_wdata[7];
          mstatus_mpp_d  = legal_mpp(mstatus_wdata[12:11]);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (pipe_drained) begin
          state_d          = REDIRECT;
          flush_d          = 1'b0;
          redirect_valid_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d          = IDLE;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer, synchronizer and CSR registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q          <= IDLE;
      ext_sync_q       <= 2'b00;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0000_0000;
      mepc_q           <= 32'h0000_0000;
      mcause_q         <= 32'h0000_0000;
      mtval_q          <= 32'h0000_0000;
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mstatus_mpp_q    <= M_MODE;
      priv_q           <= M_MODE;
    end else begin
      state_q          <= state_d;
      ext_sync_q       <= ext_sync_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mstatus_mie_q    <= mstatus_mie_d;
      mstatus_mpie_q   <= mstatus_mpie_d;
      mstatus_mpp_q    <= mstatus_mpp_d;
      priv_q           <= priv_d;
    end
  end

  assign ex_accept      = ev_trap_s | ev_mret_s;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign mtval          = mtval_q;
  assign mip            = mip_s;
  assign mstatus_mie    = mstatus_mie_q;
  assign mstatus_mpie   = mstatus_mpie_q;
  assign mstatus_mpp    = mstatus_mpp_q;
  assign priv           = priv_q;

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_machine_trap_ctrl
//
// Self-checking bench for machine_trap_ctrl. Expected trap outcomes are
// pushed to a scoreboard queue when an event is driven and popped when the
// DUT pulses ex_accept. A small mstatus/priv model produces the expectations.
// -----------------------------------------------------------------------------
module tb_machine_trap_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ex_valid;
  logic [30:0] ex_code;
  logic [31:0] ex_epc;
  logic [31:0] ex_tval;
  logic        mret_valid;
  logic [31:0] pc_next;
  logic        ext_irq;
  logic        timer_irq;
  logic        soft_irq;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mie;
  logic        mstatus_wen;
  logic [31:0] mstatus_wdata;
  logic        pipe_drained;
  logic        redirect_ready;
  logic        ex_accept;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [31:0] mip;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [1:0]  mstatus_mpp;
  logic [1:0]  priv;

  machine_trap_ctrl #(.HAS_U_MODE(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_code(ex_code), .ex_epc(ex_epc), .ex_tval(ex_tval),
    .mret_valid(mret_valid), .pc_next(pc_next),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .soft_irq(soft_irq),
    .csr_mtvec(csr_mtvec), .csr_mie(csr_mie),
    .mstatus_wen(mstatus_wen), .mstatus_wdata(mstatus_wdata),
    .pipe_drained(pipe_drained), .redirect_ready(redirect_ready),
    .ex_accept(ex_accept), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mip(mip), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mstatus_mpp(mstatus_mpp), .priv(priv)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] target;
    logic        mie;
    logic        mpie;
    logic [1:0]  mpp;
    logic [1:0]  priv;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the architectural state
  logic        m_mie, m_mpie;
  logic [1:0]  m_mpp, m_priv;
  logic [31:0] m_mepc, m_mcause, m_mtval;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tvec_target(input logic [31:0] tv, input bit is_irq, input int code);
    logic [31:0] b;
    b = {tv[31:2], 2'b00};
    if (is_irq && tv[1:0] == 2'b01) return b + 32'(code * 4);
    return b;
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b11; m_priv = 2'b11;
    m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval, input logic [31:0] target);
    exp_t e;
    e.mcause = cause; e.mepc = epc; e.mtval = tval; e.target = target;
    e.mpie = m_mie; e.mie = 1'b0; e.mpp = m_priv; e.priv = 2'b11;
    m_mpie = m_mie; m_mie = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
    m_mepc = epc; m_mcause = cause; m_mtval = tval;
    sb_q.push_back(e);
  endtask

  task automatic push_mret();
    exp_t e;
    e.mcause = m_mcause; e.mepc = m_mepc; e.mtval = m_mtval; e.target = m_mepc;
    e.mie = m_mpie; e.mpie = 1'b1; e.priv = m_mpp; e.mpp = 2'b00;
    m_mie = m_mpie; m_mpie = 1'b1; m_priv = m_mpp; m_mpp = 2'b00;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_priv"}, {30'd0, priv}, 32'h3);
    check_eq({pfx, "_mie"}, {31'd0, mstatus_mie}, 32'h0);
    check_eq({pfx, "_mpie"}, {31'd0, mstatus_mpie}, 32'h0);
    check_eq({pfx, "_mpp"}, {30'd0, mstatus_mpp}, 32'h3);
    check_eq({pfx, "_mepc"}, mepc, 32'h0);
    check_eq({pfx, "_mcause"}, mcause, 32'h0);
    check_eq({pfx, "_mtval"}, mtval, 32'h0);
    check_eq({pfx, "_rpc"}, redirect_pc, 32'h0);
    check_eq({pfx, "_flush"}, {31'd0, flush}, 32'h0);
    check_eq({pfx, "_rvalid"}, {31'd0, redirect_valid}, 32'h0);
    check_eq({pfx, "_mip"}, mip, 32'h0);
  endtask

  // mstatus CSR write; called just after a rising edge.
  task automatic wr_mstatus(input logic [31:0] wd);
    mstatus_wen = 1'b1;
    mstatus_wdata = wd;
    @(posedge CLK); #1;
    mstatus_wen = 1'b0;
    m_mie = wd[3];
    m_mpie = wd[7];
    m_mpp = (wd[12:11] == 2'b10) ? 2'b11 : wd[12:11];
    check_eq("wr_mie", {31'd0, mstatus_mie}, {31'd0, m_mie});
    check_eq("wr_mpie", {31'd0, mstatus_mpie}, {31'd0, m_mpie});
    check_eq("wr_mpp", {30'd0, mstatus_mpp}, {30'd0, m_mpp});
    check_eq("wr_priv", {30'd0, priv}, {30'd0, m_priv});
  endtask

  // Wait for the accept of an already-driven event, then walk the
  // flush / redirect handshake. Called just after a rising edge.
  task automatic do_event(input int drain_lo, input int ready_lo, input bit hold_next);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ex_accept === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("accept_seen", {31'd0, seen}, 32'd1);
    pipe_drained = (drain_lo == 0);
    redirect_ready = 1'b0;
    @(posedge CLK); #1;
    ex_valid = 1'b0; mret_valid = 1'b0;
    timer_irq = 1'b0; soft_irq = 1'b0; ext_irq = 1'b0; csr_mie = 32'h0;
    if (hold_next) begin
      ex_valid = 1'b1; ex_code = 31'd4; ex_epc = 32'h0000_4000; ex_tval = 32'h44;
      push_trap(32'd4, 32'h0000_4000, 32'h44, tvec_target(csr_mtvec, 1'b0, 0));
    end
    @(negedge CLK);
    check_eq("accept_pulse", {31'd0, ex_accept}, 32'd0);
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
      e.mcause = 32'hx; e.mepc = 32'hx; e.mtval = 32'hx; e.target = 32'hx;
      e.mie = 1'bx; e.mpie = 1'bx; e.mpp = 2'bxx; e.priv = 2'bxx;
    end else begin
      e = sb_q.pop_front();
    end
    check_eq("mcause", mcause, e.mcause);
    check_eq("mepc", mepc, e.mepc);
    check_eq("mtval", mtval, e.mtval);
    check_eq("mie", {31'd0, mstatus_mie}, {31'd0, e.mie});
    check_eq("mpie", {31'd0, mstatus_mpie}, {31'd0, e.mpie});
    check_eq("mpp", {30'd0, mstatus_mpp}, {30'd0, e.mpp});
    check_eq("priv", {30'd0, priv}, {30'd0, e.priv});
    check_eq("rpc_at_accept", redirect_pc, e.target);
    check_eq("flush_first", {31'd0, flush}, 32'd1);
    check_eq("rvalid_drain", {31'd0, redirect_valid}, 32'd0);
    for (int i = 1; i <= drain_lo; i++) begin
      @(posedge CLK); @(negedge CLK);
      check_eq("flush_hold", {31'd0, flush}, 32'd1);
      check_eq("rvalid_hold0", {31'd0, redirect_valid}, 32'd0);
      if (hold_next) check_eq("no_accept_drain", {31'd0, ex_accept}, 32'd0);
    end
    pipe_drained = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check_eq("flush_off", {31'd0, flush}, 32'd0);
    check_eq("rvalid_on", {31'd0, redirect_valid}, 32'd1);
    check_eq("rpc", redirect_pc, e.target);
    pipe_drained = 1'b0;
    for (int i = 0; i < ready_lo; i++) begin
      @(posedge CLK); @(negedge CLK);
      check_eq("rvalid_stable", {31'd0, redirect_valid}, 32'd1);
      check_eq("rpc_stable", redirect_pc, e.target);
      if (hold_next) check_eq("no_accept_redir", {31'd0, ex_accept}, 32'd0);
    end
    redirect_ready = 1'b1;
    @(posedge CLK); #1;
    redirect_ready = 1'b0;
    check_eq("rvalid_done", {31'd0, redirect_valid}, 32'd0);
    check_eq("flush_done", {31'd0, flush}, 32'd0);
  endtask

  initial begin
    nRST = 1'b0;
    ex_valid = 1'b0; ex_code = 31'd0; ex_epc = 32'h0; ex_tval = 32'h0;
    mret_valid = 1'b0; pc_next = 32'h0;
    ext_irq = 1'b0; timer_irq = 1'b0; soft_irq = 1'b0;
    csr_mtvec = 32'h0; csr_mie = 32'h0;
    mstatus_wen = 1'b0; mstatus_wdata = 32'h0;
    pipe_drained = 1'b0; redirect_ready = 1'b0;
    model_reset();

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("rst");
    check_eq("rst_accept", {31'd0, ex_accept}, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Exception, direct mode, misaligned epc
    csr_mtvec = 32'h8000_0100;
    ex_valid = 1'b1; ex_code = 31'd2; ex_epc = 32'h8000_0046; ex_tval = 32'h0000_DEAD;
    push_trap(32'h2, 32'h8000_0044, 32'h0000_DEAD, 32'h8000_0100);
    do_event(0, 0, 1'b0);

    // Drop to U mode via MRET
    wr_mstatus(32'h0000_0080);
    mret_valid = 1'b1;
    push_mret();
    do_event(0, 1, 1'b0);

    // Vectored timer interrupt from U mode
    csr_mtvec = 32'h8000_0101; csr_mie = 32'h0000_0080;
    timer_irq = 1'b1; pc_next = 32'h0000_2000;
    push_trap(32'h8000_0007, 32'h0000_2000, 32'h0, 32'h8000_011C);
    do_event(0, 0, 1'b0);

    // Masked: priv M, mstatus.MIE=0, timer pending and enabled
    timer_irq = 1'b1; csr_mie = 32'h0000_0080;
    repeat (4) begin
      @(negedge CLK);
      check_eq("masked_accept", {31'd0, ex_accept}, 32'd0);
    end
    check_eq("masked_mcause", mcause, 32'h8000_0007);
    @(posedge CLK); #1;
    timer_irq = 1'b0; csr_mie = 32'h0;

    // External interrupt synchronizer latency
    ext_irq = 1'b1;
    @(negedge CLK);
    check_eq("meip_sync0", mip, 32'h0);
    @(negedge CLK);
    check_eq("meip_sync1", mip, 32'h0);
    @(negedge CLK);
    check_eq("meip_sync2", mip, 32'h0000_0800);
    @(posedge CLK); #1;

    // MIE=1, MPP written as reserved -> reads M
    wr_mstatus(32'h0000_1008);

    // Priority among interrupts: MEI wins
    csr_mie = 32'h0000_0888; timer_irq = 1'b1; soft_irq = 1'b1;
    pc_next = 32'h0000_3002; csr_mtvec = 32'h8000_0101;
    push_trap(32'h8000_000B, 32'h0000_3000, 32'h0, tvec_target(32'h8000_0101, 1'b1, 11));
    do_event(0, 0, 1'b0);

    // Exception beats enabled interrupts in the same cycle
    wr_mstatus(32'h0000_1808);
    csr_mie = 32'h0000_0888; timer_irq = 1'b1; soft_irq = 1'b1; ext_irq = 1'b1;
    ex_valid = 1'b1; ex_code = 31'd5; ex_epc = 32'h0000_3000; ex_tval = 32'h55;
    push_trap(32'h5, 32'h0000_3000, 32'h55, tvec_target(32'h8000_0101, 1'b0, 0));
    do_event(0, 0, 1'b0);

    // MRET with slow drain and slow fetch; next exception held meanwhile
    wr_mstatus(32'h0000_0080);
    csr_mtvec = 32'h8000_0203;
    mret_valid = 1'b1;
    push_mret();
    do_event(4, 3, 1'b1);
    do_event(0, 0, 1'b0);

    // Reset during DRAIN
    ex_valid = 1'b1; ex_code = 31'd1; ex_epc = 32'h0000_5000; ex_tval = 32'h11;
    @(negedge CLK);
    check_eq("rstseq_accept", {31'd0, ex_accept}, 32'd1);
    pipe_drained = 1'b0; redirect_ready = 1'b1;
    @(posedge CLK); #1;
    ex_valid = 1'b0;
    @(negedge CLK);
    check_eq("rstseq_flush", {31'd0, flush}, 32'd1);
    check_eq("rstseq_mcause", mcause, 32'h1);
    #2 nRST = 1'b0;
    #1 check_reset_vals("midrst");
    model_reset();
    @(posedge CLK); #1;
    nRST = 1'b1;
    pipe_drained = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check_eq("postrst_rvalid", {31'd0, redirect_valid}, 32'd0);
      check_eq("postrst_flush", {31'd0, flush}, 32'd0);
      check_eq("postrst_accept", {31'd0, ex_accept}, 32'd0);
    end
    check_eq("postrst_priv", {30'd0, priv}, 32'h3);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
